input_keypad_encoder: RTL and testbench

INPUT_KEYPAD_ENCODER -- requirements
Module: input_keypad_encoder

---
 rtl/input_keypad_encoder_pkg.sv | 77 +++++++
 rtl/input_interface.sv | 25 ++
 rtl/input_keypad_scanner.sv | 64 ++++++
 rtl/input_keypad_encoder.sv | 139 +++++++++++++
 tb/tb_input_keypad_encoder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_keypad_encoder_pkg.sv
// Keypad encoder types and helpers: snapshot classification and key map.
`ifndef INPUT_INTERFACE_SV
`include "input_interface.sv"
`endif

package input_keypad_encoder_pkg;

  localparam int IC_W = `IC_N;
  typedef logic [IC_W-1:0] ic_code_t;

  localparam ic_code_t IC_NONE = `IC_NONE;
  localparam ic_code_t IC_NUM0 = `IC_NUM0;
  localparam ic_code_t IC_NUM1 = `IC_NUM1;
  localparam ic_code_t IC_NUM2 = `IC_NUM2;
  localparam ic_code_t IC_NUM3 = `IC_NUM3;
  localparam ic_code_t IC_NUM4 = `IC_NUM4;
  localparam ic_code_t IC_NUM5 = `IC_NUM5;
  localparam ic_code_t IC_NUM6 = `IC_NUM6;
  localparam ic_code_t IC_NUM7 = `IC_NUM7;
  localparam ic_code_t IC_NUM8 = `IC_NUM8;
  localparam ic_code_t IC_NUM9 = `IC_NUM9;
  localparam ic_code_t IC_ADD  = `IC_ADD;
  localparam ic_code_t IC_SUB  = `IC_SUB;
  localparam ic_code_t IC_MUL  = `IC_MUL;
  localparam ic_code_t IC_DIV  = `IC_DIV;
  localparam ic_code_t IC_EQU  = `IC_EQU;
  localparam ic_code_t IC_CLR  = `IC_CLR;

  typedef enum logic [1:0] {
    SNAP_NONE,
    SNAP_SINGLE,
    SNAP_MULTI
  } snap_class_e;

  // Count pressed keys in a full-scan snapshot and bucket the result.
  function automatic snap_class_e classify_snapshot(input logic [15:0] snap);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += 32'(snap[i]);
    if (ones == 0) return SNAP_NONE;
    if (ones == 1) return SNAP_SINGLE;
    return SNAP_MULTI;
  endfunction

  // Index (row*4+col) of the lowest pressed key; only meaningful for SINGLE.
  function automatic logic [3:0] key_index(input logic [15:0] snap);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Physical layout: 1 2 3 ADD / 4 5 6 SUB / 7 8 9 MUL / CLR 0 EQU DIV.
  function automatic ic_code_t key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return IC_NUM1;
      4'd1:    return IC_NUM2;
      4'd2:    return IC_NUM3;
      4'd3:    return IC_ADD;
      4'd4:    return IC_NUM4;
      4'd5:    return IC_NUM5;
      4'd6:    return IC_NUM6;
      4'd7:    return IC_SUB;
      4'd8:    return IC_NUM7;
      4'd9:    return IC_NUM8;
      4'd10:   return IC_NUM9;
      4'd11:   return IC_MUL;
      4'd12:   return IC_CLR;
      4'd13:   return IC_NUM0;
      4'd14:   return IC_EQU;
      default: return IC_DIV;
    endcase
  endfunction

endpackage

// File: rtl/input_interface.sv
// Shared command codes between input devices and the calculator controller.
`ifndef INPUT_INTERFACE_SV
`define INPUT_INTERFACE_SV

`define IC_N    5

`define IC_NONE 5'd0
`define IC_NUM0 5'd1
`define IC_NUM1 5'd2
`define IC_NUM2 5'd3
`define IC_NUM3 5'd4
`define IC_NUM4 5'd5
`define IC_NUM5 5'd6
`define IC_NUM6 5'd7
`define IC_NUM7 5'd8
`define IC_NUM8 5'd9
`define IC_NUM9 5'd10
`define IC_ADD  5'd11
`define IC_SUB  5'd12
`define IC_MUL  5'd13
`define IC_DIV  5'd14
`define IC_EQU  5'd15
`define IC_CLR  5'd16

`endif

// File: rtl/input_keypad_scanner.sv
// Row scanner: drives one row low at a time, synchronizes the column
// sense lines and assembles a 16-bit pressed-key snapshot per full scan.
module input_keypad_scanner #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [3:0]  kp_row,
  input  logic [3:0]  kp_col,
  output logic [15:0] snapshot,
  output logic        snap_valid
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] div_cnt;
  logic [1:0]  row;
  logic [3:0]  col_meta;
  logic [3:0]  col_sync;
  logic [11:0] snap_acc;

  // Row drive is a pure decode of the row register, so it resets with it.
  assign kp_row = ~(4'b0001 << row);

  // Two-flop synchronizer for the asynchronous column inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the meta->sync chain really is two stages.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= kp_col;
      col_sync <= col_meta;
    end
  end

  // Slot timer, row sequencing and snapshot assembly; columns are sampled
  // in the last clock of each row slot so the synchronizer has settled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_cnt    <= '0;
      row        <= '0;
      snap_acc   <= '0;
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        row     <= row + 2'd1;
        if (row == 2'd3) begin
          snapshot   <= {~col_sync, snap_acc};
          snap_valid <= 1'b1;
        end else begin
          snap_acc[{row, 2'b00} +: 4] <= ~col_sync;
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/input_keypad_encoder.sv
// 4x4 keypad encoder: debounces single key presses from the scanner and
// delivers one command code per press through a valid/ack handshake.
`ifndef INPUT_INTERFACE_SV
`include "input_interface.sv"
`endif

module input_keypad_encoder
  import input_keypad_encoder_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [3:0]       kp_row,
  input  logic [3:0]       kp_col,
  output logic [`IC_N-1:0] in_cmd,
  output logic             in_valid,
  input  logic             in_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESENT,
    ST_RELEASE
  } state_e;

  localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_N);

  logic [15:0] snapshot;
  logic        snap_valid;
  snap_class_e snap_class;

  state_e      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  ic_code_t    cmd_q, cmd_d;

  input_keypad_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .Clock      (Clock),
    .Reset      (Reset),
    .kp_row     (kp_row),
    .kp_col     (kp_col),
    .snapshot   (snapshot),
    .snap_valid (snap_valid)
  );

  assign snap_class = classify_snapshot(snapshot);
  assign in_valid   = valid_q;
  assign in_cmd     = cmd_q;

  // State and registered outputs; reset drops any pending command.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      cmd_q   <= IC_NONE;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next-state logic: debounce on whole snapshots, hold the command until
  // acknowledged, then wait for a stable all-released keypad.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;

    case (state_q)
      ST_IDLE: begin
        if (snap_valid && snap_class == SNAP_SINGLE) begin
          key_d   = snapshot;
          idx_d   = key_index(snapshot);
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (snap_valid) begin
          if (snapshot == key_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DB_TARGET) begin
              valid_d = 1'b1;
              cmd_d   = key_code(idx_q);
              state_d = ST_PRESENT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_PRESENT: begin
        // Key activity is deliberately ignored here: once offered, the
        // command stays up until the controller takes it.
        if (valid_q && in_ack) begin
          valid_d = 1'b0;
          cmd_d   = IC_NONE;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (snap_valid) begin
          if (snap_class == SNAP_NONE) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DB_TARGET) state_d = ST_IDLE;
          end else begin
            cnt_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_keypad_encoder.sv
// Scoreboard bench for input_keypad_encoder: a behavioural keypad drives
// the columns, expected commands are queued by the stimulus and a monitor
// checks every delivery and handshake independently.
module tb_input_keypad_encoder;
  import input_keypad_encoder_pkg::*;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;
  localparam int SCAN       = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic [IC_W-1:0] in_cmd;
  logic        in_valid;
  logic        in_ack = 1'b0;

  logic [15:0] pressed = '0;
  bit          ack_en = 1'b1;
  int          ack_delay = 0;

  int vectors = 0;
  int miscompares = 0;
  logic [IC_W-1:0] exp_q[$];

  // Reference key map, rows 0..3 by columns 0..3.
  logic [IC_W-1:0] ref_map [4][4];
  initial begin
    ref_map[0] = '{IC_NUM1, IC_NUM2, IC_NUM3, IC_ADD};
    ref_map[1] = '{IC_NUM4, IC_NUM5, IC_NUM6, IC_SUB};
    ref_map[2] = '{IC_NUM7, IC_NUM8, IC_NUM9, IC_MUL};
    ref_map[3] = '{IC_CLR,  IC_NUM0, IC_EQU,  IC_DIV};
  end

  function automatic logic [IC_W-1:0] ref_code(input int idx);
    return ref_map[idx / 4][idx % 4];
  endfunction

  input_keypad_encoder #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .kp_row   (kp_row),
    .kp_col   (kp_col),
    .in_cmd   (in_cmd),
    .in_valid (in_valid),
    .in_ack   (in_ack)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its column to its row.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_row[r]) kp_col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller model: random ack delay while valid, random noise on ack otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (in_valid && ack_en) begin
        if (ack_delay > 0) begin
          in_ack = 1'b0;
          ack_delay--;
        end else begin
          in_ack = 1'b1;
          ack_delay = $urandom_range(0, 5);
        end
      end else if (in_valid) begin
        in_ack = 1'b0;
      end else begin
        in_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: samples just after each rising edge.
  initial begin
    logic pv;
    logic [IC_W-1:0] pc;
    pv = 1'b0;
    pc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && in_ack) begin
        check("ack_drops_valid", 32'(in_valid), 32'(0));
        check("ack_clears_cmd", 32'(in_cmd), 32'(IC_NONE));
      end else if (pv) begin
        check("valid_held", 32'(in_valid), 32'(1));
        check("cmd_stable", 32'(in_cmd), 32'(pc));
      end else if (in_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_delivery: got cmd %0h expected none at %0t", in_cmd, $time);
        end else begin
          check("delivery_cmd", 32'(in_cmd), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_cmd_none", 32'(in_cmd), 32'(IC_NONE));
      end
      pv = in_valid;
      pc = in_cmd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_delivered"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (in_valid && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_acked"}, 32'(in_valid), 32'(0));
  endtask

  task automatic run_key(input string name, input int idx);
    ack_en = 1'b1;
    pressed = '0;
    pressed[idx] = 1'b1;
    exp_q.push_back(ref_code(idx));
    wait_drained(name, 120);
    wait_idle(name, 200);
    tick($urandom_range(0, 2) * SCAN);
    pressed = '0;
    tick(6 * SCAN);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int k1, k2;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", 32'(in_valid), 32'(0));
    check("reset_cmd", 32'(in_cmd), 32'(IC_NONE));
    check("reset_row", 32'(kp_row), 32'(4'b1110));
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Row1/col2 held: one NUM6 within the debounce latency window, no repeat.
    ack_en = 1'b0;
    pressed[6] = 1'b1;
    exp_q.push_back(ref_code(6));
    lat = 0;
    while (!in_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t6_latency_min", 32'(lat >= DEBOUNCE_N * SCAN), 32'(1));
    check("t6_latency_max", 32'(lat <= (DEBOUNCE_N + 2) * SCAN + 10), 32'(1));
    tick(5);
    ack_en = 1'b1;
    wait_idle("t6", 50);
    tick(5 * SCAN);
    check("t6_no_repeat", 32'(in_valid), 32'(0));
    pressed = '0;
    tick(6 * SCAN);

    // Row3/col3 with ack withheld, released before the ack.
    ack_en = 1'b0;
    pressed[15] = 1'b1;
    exp_q.push_back(ref_code(15));
    wait_drained("t15", 120);
    tick(100);
    check("t15_valid_held", 32'(in_valid), 32'(1));
    check("t15_cmd_held", 32'(in_cmd), 32'(IC_DIV));
    pressed = '0;
    tick(5 * SCAN);
    check("t15_valid_after_release", 32'(in_valid), 32'(1));
    ack_en = 1'b1;
    wait_idle("t15", 50);
    tick(6 * SCAN);

    // Row0/col0 bouncing for two scans, then stable.
    for (int i = 0; i < 7; i++) begin
      pressed[0] = ~pressed[0];
      tick(5);
    end
    pressed[0] = 1'b1;
    exp_q.push_back(ref_code(0));
    wait_drained("bounce", 150);
    wait_idle("bounce", 50);
    pressed = '0;
    tick(6 * SCAN);

    // Two keys together never deliver; releasing one delivers the other.
    pressed[3] = 1'b1;
    pressed[9] = 1'b1;
    tick(8 * SCAN);
    check("multi_no_valid", 32'(in_valid), 32'(0));
    exp_q.push_back(ref_code(3));
    pressed[9] = 1'b0;
    wait_drained("multi_release", 150);
    wait_idle("multi_release", 50);
    pressed = '0;
    tick(6 * SCAN);

    // Reset while presenting: outputs drop immediately, then re-debounce.
    ack_en = 1'b0;
    pressed[5] = 1'b1;
    exp_q.push_back(ref_code(5));
    wait_drained("rst_first", 120);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(in_valid), 32'(0));
    check("midrst_cmd", 32'(in_cmd), 32'(IC_NONE));
    check("midrst_row", 32'(kp_row), 32'(4'b1110));
    tick(2);
    exp_q.push_back(ref_code(5));
    rst_n = 1'b1;
    ack_en = 1'b1;
    wait_drained("rst_second", 150);
    wait_idle("rst_second", 50);
    pressed = '0;
    tick(6 * SCAN);

    // Same key twice: two distinct deliveries.
    run_key("repress_a", 10);
    run_key("repress_b", 10);

    // Randomized presses, single and multiple.
    for (int n = 0; n < 12; n++) begin
      k1 = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        k2 = (k1 + $urandom_range(1, 15)) % 16;
        pressed = '0;
        pressed[k1] = 1'b1;
        pressed[k2] = 1'b1;
        tick(6 * SCAN);
        check("rand_multi_no_valid", 32'(in_valid), 32'(0));
        pressed = '0;
        tick(6 * SCAN);
      end else begin
        run_key("rand_key", k1);
      end
    end

    tick(4 * SCAN);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
